// File: rtl/csr_regfile.sv
// Machine-mode CSR register file: trap state, privilege, 64-bit mcycle, system-jump targets.
// Optional perf counters (B03-B09) are built only when FALCO_CSR_PERF_CNT_EN is defined.
module csr_regfile #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter int unsigned ROB_ENTRY_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [11:0]            csr_raddr_i,
  output logic [31:0]            csr_data_o,
  input  logic                   csr_we_i,
  input  logic [11:0]            csr_waddr_i,
  input  logic [31:0]            csr_wdata_i,
  input  logic                   sys_jump_i,
  input  logic [1:0]             sys_jump_csr_addr_i,
  output logic                   sys_jump_o,
  output logic [31:0]            sys_jump_csr_data_o,
  output logic [1:0]             privilege_level_o,
  input  logic                   xcpt_valid_i,
  input  logic [3:0]             xcpt_cause_i,
  input  logic [31:0]            xcpt_tval_i,
  input  logic [31:0]            pc,
  input  logic                   exe_stall,
  input  logic                   exe_is_branch,
  input  logic                   exe_misspredict,
  input  logic                   start_recovery,
  input  logic                   recovery_procedure,
  input  logic [ROB_ENTRY_W:0]   recovery_distance,
  input  logic [31:0]            start_recovery_tag
);

  localparam int unsigned XLEN = 32;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  localparam logic [XLEN-1:0] MSTATUS_MASK = 32'h0000_1888;
  localparam logic [XLEN-1:0] ALIGN_MASK   = 32'hFFFF_FFFC;
  localparam logic [1:0]      PRIV_M       = 2'b11;
  localparam logic [1:0]      PRIV_U       = 2'b00;

  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [1:0]      mpp_q, mpp_d;
  logic [1:0]      priv_q, priv_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] mcycle_lo_q, mcycle_lo_d;
  logic [XLEN-1:0] mcycle_hi_q, mcycle_hi_d;
  logic            jump_q, jump_d;
  logic [XLEN-1:0] jump_data_q, jump_data_d;

  logic            wr_mstatus, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval;
  logic            wr_mcycle, wr_mcycleh, wr_any;
  logic            is_mret;
  logic            lo_carry;
  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] wdata_masked;
  logic [XLEN-1:0] rd_val;
  logic [XLEN-1:0] perf_rdata;

  assign mstatus_val = {19'b0, mpp_q, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};

  // A same-cycle exception owns mstatus and the trap registers, so those writes are dropped.
  assign wr_mstatus  = csr_we_i && (csr_waddr_i == ADDR_MSTATUS) && !xcpt_valid_i;
  assign wr_mtvec    = csr_we_i && (csr_waddr_i == ADDR_MTVEC);
  assign wr_mscratch = csr_we_i && (csr_waddr_i == ADDR_MSCRATCH);
  assign wr_mepc     = csr_we_i && (csr_waddr_i == ADDR_MEPC) && !xcpt_valid_i;
  assign wr_mcause   = csr_we_i && (csr_waddr_i == ADDR_MCAUSE) && !xcpt_valid_i;
  assign wr_mtval    = csr_we_i && (csr_waddr_i == ADDR_MTVAL) && !xcpt_valid_i;
  assign wr_mcycle   = csr_we_i && (csr_waddr_i == ADDR_MCYCLE);
  assign wr_mcycleh  = csr_we_i && (csr_waddr_i == ADDR_MCYCLEH);
  assign wr_any      = wr_mstatus | wr_mtvec | wr_mscratch | wr_mepc | wr_mcause | wr_mtval |
                       wr_mcycle | wr_mcycleh;

  assign is_mret  = sys_jump_i && (sys_jump_csr_addr_i == 2'd1);
  assign lo_carry = (mcycle_lo_q == '1);

  // Write data as it will be stored, used for read-after-write forwarding.
  always_comb begin
    wdata_masked = csr_wdata_i;
    case (csr_waddr_i)
      ADDR_MSTATUS:          wdata_masked = csr_wdata_i & MSTATUS_MASK;
      ADDR_MTVEC, ADDR_MEPC: wdata_masked = csr_wdata_i & ALIGN_MASK;
      default:               wdata_masked = csr_wdata_i;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (csr_raddr_i)
      ADDR_MSTATUS:  rd_val = mstatus_val;
      ADDR_MTVEC:    rd_val = mtvec_q;
      ADDR_MSCRATCH: rd_val = mscratch_q;
      ADDR_MEPC:     rd_val = mepc_q;
      ADDR_MCAUSE:   rd_val = mcause_q;
      ADDR_MTVAL:    rd_val = mtval_q;
      ADDR_MCYCLE:   rd_val = mcycle_lo_q;
      ADDR_MCYCLEH:  rd_val = mcycle_hi_q;
      ADDR_MHARTID:  rd_val = '0;
      default:       rd_val = perf_rdata;
    endcase
  end

  assign csr_data_o = (wr_any && (csr_waddr_i == csr_raddr_i)) ? wdata_masked : rd_val;

  // Next state: software writes first, then exception or mret trap bookkeeping on top.
  always_comb begin
    mie_d       = mie_q;
    mpie_d      = mpie_q;
    mpp_d       = mpp_q;
    priv_d      = priv_q;
    mtvec_d     = mtvec_q;
    mscratch_d  = mscratch_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    mtval_d     = mtval_q;
    mcycle_lo_d = mcycle_lo_q + XLEN'(1);
    mcycle_hi_d = mcycle_hi_q + XLEN'(lo_carry);
    jump_d      = sys_jump_i;
    jump_data_d = jump_data_q;

    if (wr_mstatus) begin
      mie_d  = csr_wdata_i[3];
      mpie_d = csr_wdata_i[7];
      mpp_d  = csr_wdata_i[12:11];
    end
    if (wr_mtvec)    mtvec_d     = csr_wdata_i & ALIGN_MASK;
    if (wr_mscratch) mscratch_d  = csr_wdata_i;
    if (wr_mepc)     mepc_d      = csr_wdata_i & ALIGN_MASK;
    if (wr_mcause)   mcause_d    = csr_wdata_i;
    if (wr_mtval)    mtval_d     = csr_wdata_i;
    if (wr_mcycle)   mcycle_lo_d = csr_wdata_i;
    if (wr_mcycleh)  mcycle_hi_d = csr_wdata_i;

    if (xcpt_valid_i) begin
      mepc_d   = pc & ALIGN_MASK;
      mcause_d = {28'b0, xcpt_cause_i};
      mtval_d  = xcpt_tval_i;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      mpp_d    = priv_q;
      priv_d   = PRIV_M;
    end else if (is_mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
      priv_d = mpp_q;
      mpp_d  = PRIV_U;
    end

    // Targets use post-update values; an exception always vectors through mtvec.
    if (sys_jump_i) begin
      if (xcpt_valid_i || (sys_jump_csr_addr_i == 2'd0)) begin
        jump_data_d = mtvec_d;
      end else if (sys_jump_csr_addr_i == 2'd1) begin
        jump_data_d = mepc_d;
      end else begin
        jump_data_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q       <= 1'b0;
      mpie_q      <= 1'b0;
      mpp_q       <= 2'b00;
      priv_q      <= PRIV_M;
      mtvec_q     <= MTVEC_RESET;
      mscratch_q  <= '0;
      mepc_q      <= '0;
      mcause_q    <= '0;
      mtval_q     <= '0;
      mcycle_lo_q <= '0;
      mcycle_hi_q <= '0;
      jump_q      <= 1'b0;
      jump_data_q <= '0;
    end else begin
      mie_q       <= mie_d;
      mpie_q      <= mpie_d;
      mpp_q       <= mpp_d;
      priv_q      <= priv_d;
      mtvec_q     <= mtvec_d;
      mscratch_q  <= mscratch_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
      mtval_q     <= mtval_d;
      mcycle_lo_q <= mcycle_lo_d;
      mcycle_hi_q <= mcycle_hi_d;
      jump_q      <= jump_d;
      jump_data_q <= jump_data_d;
    end
  end

  assign sys_jump_o          = jump_q;
  assign sys_jump_csr_data_o = jump_data_q;
  assign privilege_level_o   = priv_q;

`ifdef FALCO_CSR_PERF_CNT_EN
  localparam logic [11:0] ADDR_BRANCH  = 12'hB03;
  localparam logic [11:0] ADDR_MISPRED = 12'hB04;
  localparam logic [11:0] ADDR_STALL   = 12'hB05;
  localparam logic [11:0] ADDR_RECOV   = 12'hB06;
  localparam logic [11:0] ADDR_RCYC    = 12'hB07;
  localparam logic [11:0] ADDR_RDIST   = 12'hB08;
  localparam logic [11:0] ADDR_RTAG    = 12'hB09;

  logic [XLEN-1:0] branch_q, branch_d, mispred_q, mispred_d, stall_q, stall_d;
  logic [XLEN-1:0] recov_q, recov_d, rcyc_q, rcyc_d, rdist_q, rdist_d, rtag_q, rtag_d;

  function automatic logic [XLEN-1:0] sat_add(input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [XLEN:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[XLEN] ? '1 : sum[XLEN-1:0];
  endfunction

  always_comb begin
    branch_d  = branch_q;
    mispred_d = mispred_q;
    stall_d   = stall_q;
    recov_d   = recov_q;
    rcyc_d    = rcyc_q;
    rdist_d   = rdist_q;
    rtag_d    = rtag_q;
    if (exe_is_branch && !exe_stall)   branch_d  = sat_add(branch_q, XLEN'(1));
    if (exe_misspredict && !exe_stall) mispred_d = sat_add(mispred_q, XLEN'(1));
    if (exe_stall)                     stall_d   = sat_add(stall_q, XLEN'(1));
    if (recovery_procedure)            rcyc_d    = sat_add(rcyc_q, XLEN'(1));
    if (start_recovery) begin
      recov_d = sat_add(recov_q, XLEN'(1));
      rdist_d = sat_add(rdist_q, XLEN'(recovery_distance));
      rtag_d  = start_recovery_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_q  <= '0;
      mispred_q <= '0;
      stall_q   <= '0;
      recov_q   <= '0;
      rcyc_q    <= '0;
      rdist_q   <= '0;
      rtag_q    <= '0;
    end else begin
      branch_q  <= branch_d;
      mispred_q <= mispred_d;
      stall_q   <= stall_d;
      recov_q   <= recov_d;
      rcyc_q    <= rcyc_d;
      rdist_q   <= rdist_d;
      rtag_q    <= rtag_d;
    end
  end

  always_comb begin
    perf_rdata = '0;
    case (csr_raddr_i)
      ADDR_BRANCH:  perf_rdata = branch_q;
      ADDR_MISPRED: perf_rdata = mispred_q;
      ADDR_STALL:   perf_rdata = stall_q;
      ADDR_RECOV:   perf_rdata = recov_q;
      ADDR_RCYC:    perf_rdata = rcyc_q;
      ADDR_RDIST:   perf_rdata = rdist_q;
      ADDR_RTAG:    perf_rdata = rtag_q;
      default:      perf_rdata = '0;
    endcase
  end
`else
  logic unused_perf_inputs;
  assign unused_perf_inputs = ^{exe_stall, exe_is_branch, exe_misspredict, start_recovery,
                                recovery_procedure, recovery_distance, start_recovery_tag};
  assign perf_rdata = '0;
`endif

endmodule
